// File: rtl/clk_reset_sequencer_if.sv
// Lock input and staged reset/status outputs of the reset sequencer.
// The sequencer takes the master side; whatever feeds the PLL lock and consumes the resets takes the slave side.
interface clk_reset_sequencer_if;
   logic       pll_locked;
   logic       rst_core_out;
   logic       rst_video_out;
   logic       ready;
   logic       lock_timeout;
   logic [7:0] lock_loss_count;

   modport master (
      input  pll_locked,
      output rst_core_out,
      output rst_video_out,
      output ready,
      output lock_timeout,
      output lock_loss_count
   );

   modport slave (
      output pll_locked,
      input  rst_core_out,
      input  rst_video_out,
      input  ready,
      input  lock_timeout,
      input  lock_loss_count
   );
endinterface

// File: rtl/clk_reset_sequencer.sv
// Synchronises PLL lock, waits for it to be stable, then releases core and video resets in order.
// Any loss of lock after release drops straight back to full reset and is counted.
module clk_reset_sequencer #(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_STABLE  = 1024,
   parameter int STAGE_DELAY  = 16,
   parameter int LOCK_TIMEOUT = 1048576
) (
   input  logic                  clk,
   input  logic                  rst,
   clk_reset_sequencer_if.master bus
);

   localparam int STABLE_W = $clog2(LOCK_STABLE + 1);
   localparam int STAGE_W  = $clog2(STAGE_DELAY + 1);
   localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);

   localparam logic [STABLE_W-1:0] STABLE_DONE = STABLE_W'(LOCK_STABLE);
   localparam logic [STAGE_W-1:0]  STAGE_LAST  = STAGE_W'(STAGE_DELAY - 1);
   localparam logic [TMO_W-1:0]    TMO_MAX     = TMO_W'(LOCK_TIMEOUT);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_STABLE    = 2'd1,
      ST_CORE_REL  = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t                r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [STABLE_W-1:0]   r_stable_cnt;
   logic [STAGE_W-1:0]    r_stage_cnt;
   logic [TMO_W-1:0]      r_tmo_cnt;
   logic                  r_rst_core;
   logic                  r_rst_video;
   logic                  r_ready;
   logic                  r_lock_timeout;
   logic [7:0]            r_loss_cnt;

   logic                  w_locked_s;
   logic [STABLE_W-1:0]   w_stable_inc;
   logic [TMO_W-1:0]      w_tmo_inc;
   logic                  w_tmo_hit;

   // Lock synchroniser: the only logic that ever samples pll_locked.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};
      end
   end

   assign w_locked_s   = r_sync[SYNC_STAGES-1];
   // Stable counter is zero in WAIT_LOCK, so the first high edge lands on 1.
   assign w_stable_inc = r_stable_cnt + STABLE_W'(1);
   assign w_tmo_inc    = (r_tmo_cnt == TMO_MAX) ? r_tmo_cnt : r_tmo_cnt + TMO_W'(1);
   assign w_tmo_hit    = (w_tmo_inc == TMO_MAX);

   // Sequencer FSM with registered reset/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_WAIT_LOCK;
         r_stable_cnt   <= '0;
         r_stage_cnt    <= '0;
         r_tmo_cnt      <= '0;
         r_rst_core     <= 1'b1;
         r_rst_video    <= 1'b1;
         r_ready        <= 1'b0;
         r_lock_timeout <= 1'b0;
         r_loss_cnt     <= 8'd0;
      end else begin
         case (r_state)
            ST_WAIT_LOCK, ST_STABLE: begin
               if (w_tmo_hit) begin
                  r_lock_timeout <= 1'b1;
               end
               if (!w_locked_s) begin
                  r_state      <= ST_WAIT_LOCK;
                  r_stable_cnt <= '0;
                  r_tmo_cnt    <= w_tmo_inc;
               end else if (w_stable_inc == STABLE_DONE) begin
                  r_state      <= ST_CORE_REL;
                  r_stable_cnt <= '0;
                  r_stage_cnt  <= '0;
                  r_tmo_cnt    <= '0;
                  r_rst_core   <= 1'b0;
               end else begin
                  r_state      <= ST_STABLE;
                  r_stable_cnt <= w_stable_inc;
                  r_tmo_cnt    <= w_tmo_inc;
               end
            end
            ST_CORE_REL: begin
               // Lock loss takes priority over the stage terminal count.
               if (!w_locked_s) begin
                  r_state     <= ST_WAIT_LOCK;
                  r_stage_cnt <= '0;
                  r_rst_core  <= 1'b1;
                  r_rst_video <= 1'b1;
                  r_ready     <= 1'b0;
                  r_loss_cnt  <= (r_loss_cnt == 8'd255) ? r_loss_cnt : r_loss_cnt + 8'd1;
               end else if (r_stage_cnt == STAGE_LAST) begin
                  r_state     <= ST_RUN;
                  r_stage_cnt <= '0;
                  r_rst_video <= 1'b0;
                  r_ready     <= 1'b1;
               end else begin
                  r_stage_cnt <= r_stage_cnt + STAGE_W'(1);
               end
            end
            ST_RUN: begin
               if (!w_locked_s) begin
                  r_state     <= ST_WAIT_LOCK;
                  r_rst_core  <= 1'b1;
                  r_rst_video <= 1'b1;
                  r_ready     <= 1'b0;
                  r_loss_cnt  <= (r_loss_cnt == 8'd255) ? r_loss_cnt : r_loss_cnt + 8'd1;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_state      <= ST_WAIT_LOCK;
               r_stable_cnt <= '0;
               r_stage_cnt  <= '0;
               r_rst_core   <= 1'b1;
               r_rst_video  <= 1'b1;
               r_ready      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_core_out    = r_rst_core;
   assign bus.rst_video_out   = r_rst_video;
   assign bus.ready           = r_ready;
   assign bus.lock_timeout    = r_lock_timeout;
   assign bus.lock_loss_count = r_loss_cnt;

endmodule

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
- Sits directly downstream of the 25 MHz pixel PLL and consumes its lock indication.
- Filters and synchronises the PLL lock, holds the design in reset until lock is stable, then releases core and video resets in a fixed staged order.
- Re-enters reset on lock loss, and reports a lock timeout and a count of lock-loss events for debug.
- Runs entirely in the PLL output clock domain.

Parameters:
- SYNC_STAGES, 2, number of flops in the pll_locked synchroniser (minimum 2).
- LOCK_STABLE, 1024, consecutive synchronised-high lock cycles required before core reset is released.
- STAGE_DELAY, 16, cycles between core reset release and video reset release (minimum 1).
- LOCK_TIMEOUT, 1048576, cycles without reaching release before lock_timeout is flagged.
- Counter widths are derived with $clog2 of the largest value each counter must hold.

Ports:
- clk  input  1  25 MHz PLL output clock.
- rst  input  1  synchronous active-high reset / external reset request.
- pll_locked  input  1  raw PLL lock, asynchronous to clk.
- rst_core_out  output  1  active-high synchronous reset for the core logic.
- rst_video_out  output  1  active-high synchronous reset for the video pipeline.
- ready  output  1  high when both resets are released.
- lock_timeout  output  1  sticky flag: lock never became stable within LOCK_TIMEOUT.
- lock_loss_count  output  8  saturating count of lock losses after release.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst high at an edge):
  - Synchroniser flops cleared; state=WAIT_LOCK; all counters cleared.
  - rst_core_out=1, rst_video_out=1, ready=0, lock_timeout=0, lock_loss_count=0.
  - rst held high keeps these values every cycle. rst mid-sequence aborts to WAIT_LOCK immediately.
- Synchroniser: locked_s is pll_locked delayed by SYNC_STAGES flops. No other logic samples pll_locked directly.
- State machine (transitions on clk edges):
  - WAIT_LOCK: both resets asserted; stable counter=0. locked_s=1 → STABLE with stable counter=1.
  - STABLE: both resets asserted.
    - locked_s=1 → counter increments.
    - locked_s=0 → WAIT_LOCK, counter=0.
    - When locked_s has been sampled high for LOCK_STABLE consecutive edges → CORE_REL; rst_core_out deasserts at that same edge.
  - CORE_REL: rst_core_out=0, rst_video_out=1; stage counter counts edges.
    - After STAGE_DELAY edges in CORE_REL → RUN; rst_video_out deasserts and ready asserts at that same edge.
  - RUN: all resets deasserted, ready=1.
- Lock loss:
  - locked_s=0 sampled in CORE_REL or RUN → WAIT_LOCK.
  - rst_core_out and rst_video_out reassert and ready drops on that edge; no partial release is ever held.
  - lock_loss_count increments by 1 on that edge and saturates at 255.
  - Lock loss in WAIT_LOCK/STABLE does not count.
- Timeout:
  - Timeout counter increments every edge spent in WAIT_LOCK or STABLE and clears on entry to CORE_REL.
  - Reaching LOCK_TIMEOUT sets lock_timeout and the counter holds (no wrap).
  - lock_timeout is sticky until rst; it does not block release if lock later stabilises.
- Outputs are registered (no combinational path from pll_locked to any output).
- Simultaneous events:
  - rst dominates all.
  - locked_s=0 on the same edge as a stage counter terminal count → lock loss wins (go to WAIT_LOCK, no release).
- Lock glitch shorter than one clk: may or may not be seen after sync. If seen, it is treated as a full lock loss.

Test Plan:
Params for all tests: SYNC_STAGES=2, LOCK_STABLE=8, STAGE_DELAY=4, LOCK_TIMEOUT=32.
- Clean lock: rst for 3 edges, then pll_locked=1 before edge 1.
  - locked_s first sampled high at edge 3.
  - rst_core_out falls after edge 10; rst_video_out falls and ready rises after edge 14.
  - lock_loss_count=0, lock_timeout=0.
- Lock bounce: pll_locked high 5 cycles, low 1, then high.
  - No release until 8 consecutive synced-high edges after the bounce; lock_loss_count stays 0.
- Loss in RUN: after ready, drop pll_locked for 3 cycles.
  - Both resets reassert 2–3 edges later (sync delay); ready=0; lock_loss_count=1.
  - Re-release follows the full 8+4 cycle sequence.
- Loss in CORE_REL: drop pll_locked 2 edges after core release.
  - rst_core_out reasserts; rst_video_out never deasserted; count=1.
- Timeout: pll_locked held low 40 cycles.
  - lock_timeout=1 after edge 32 and stays 1; a later stable lock still releases.
  - rst clears lock_timeout.
- Saturation/reset: force 300 RUN lock losses → count holds 255.
  - rst mid-STABLE → all outputs return to reset values next edge.
